// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: drains an upstream FIFO into a 2-entry in-order output buffer under an IDLE/ACTIVE/PAUSE/DRAIN FSM.
// Latency: 2 cycles from fifo_rd_en to out_valid; sustained 1 word/cycle while the FIFO is non-empty and out_ready is high.
// Backpressure: out_ready low fills the buffer, then fifo_rd_en stops so buffered plus in-flight words never exceed 2.
//
// Ports: clk, reset (async active-low); enable/pause control; fifo_empty/fifo_error/fifo_data_out
//        from the upstream FIFO, fifo_rd_en to it; out_valid/out_ready/out_data downstream;
//        state (FSM encoding), err_sticky, pop_count (handshake counter).
// Build option: define FIFO_POP_CTRL_CNT_EN to enable the pop_count counter (otherwise it is tied to 0).
module fifo_pop_ctrl #(
  parameter int TAMANO_DATOS = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    pause,
  input  logic                    fifo_empty,
  input  logic                    fifo_error,
  input  logic [TAMANO_DATOS-1:0] fifo_data_out,
  output logic                    fifo_rd_en,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [TAMANO_DATOS-1:0] out_data,
  output logic [1:0]              state,
  output logic                    err_sticky,
  output logic [15:0]             pop_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSE  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [1:0]              occ_q, occ_d;
  logic                    inflight_q;
  logic [TAMANO_DATOS-1:0] buf0_q, buf0_d;   // buf0 is always the oldest entry
  logic [TAMANO_DATOS-1:0] buf1_q, buf1_d;
  logic                    err_q;
  logic                    pop;
  logic                    rd_en;
  logic [1:0]              pending;

  assign pop = (occ_q != 2'd0) && out_ready;

  // Words that will occupy the buffer after this edge. pop implies occ>=1, so no underflow,
  // and occ+inflight never exceeds 2, so 2 bits are enough.
  assign pending = occ_q + {1'b0, inflight_q} - {1'b0, pop};

  // Kept combinational: it must react to this cycle's fifo_empty and out_ready to reach
  // one word per cycle without overrunning the 2-entry buffer.
  assign rd_en = (state_q == ACTIVE) && !fifo_empty && (pending < 2'd2);

  // Buffer next state: pop shifts buf1 into buf0, capture appends behind whatever remains.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({inflight_q, pop})
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_data_out;
        else               buf1_d = fifo_data_out;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_data_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      inflight_q <= rd_en;
      if (fifo_error) err_q <= 1'b1;
      case (state_q)
        IDLE:   if (enable) state_q <= ACTIVE;
        ACTIVE: begin
          if (!enable)    state_q <= DRAIN;
          else if (pause) state_q <= PAUSE;
        end
        PAUSE: begin
          if (!enable)     state_q <= DRAIN;
          else if (!pause) state_q <= ACTIVE;
        end
        // Leave as soon as the buffer empties at this edge; rd_en is never high in DRAIN,
        // so nothing can still be in flight afterwards.
        DRAIN:  if (occ_d == 2'd0 && !rd_en) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en = rd_en;
  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = buf0_q;
  assign state      = state_q;
  assign err_sticky = err_q;

`ifdef FIFO_POP_CTRL_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt_q <= 16'd0;
    else if (pop) cnt_q <= cnt_q + 16'd1;   // wraps naturally at 16'hFFFF
  end

  assign pop_count = cnt_q;
`else
  assign pop_count = 16'd0;
`endif

endmodule
